// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartE,
    input  logic [2:0]       FunctE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] ResultE
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         funct_q, funct_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               done_q, done_d;

    logic               sgn_a, sgn_b, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, iter, prod;
    logic [WIDTH-1:0]   quo, rem, final_res, special_res;

    // Operand signedness from funct3
    assign sgn_a = (FunctE == 3'b001) || (FunctE == 3'b010) ||
                   (FunctE == 3'b100) || (FunctE == 3'b110);
    assign sgn_b = (FunctE == 3'b001) || (FunctE == 3'b100) ||
                   (FunctE == 3'b110);
    assign a_neg = sgn_a & SrcAE[WIDTH-1];
    assign b_neg = sgn_b & SrcBE[WIDTH-1];
    assign a_mag = a_neg ? -SrcAE : SrcAE;
    assign b_mag = b_neg ? -SrcBE : SrcBE;

    assign div_zero = FunctE[2] & (SrcBE == '0);
    assign div_ovf  = FunctE[2] & ~FunctE[0] & (&SrcBE) &
                      (SrcAE == {1'b1, {(WIDTH-1){1'b0}}});
    assign special_res = div_zero ? (FunctE[1] ? SrcAE : '1)
                                  : (FunctE[1] ? '0
                                     : {1'b1, {(WIDTH-1){1'b0}}});

    // acc holds {high, low}: product/multiplier or remainder/dividend
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_q};
    assign div_next = diff[WIDTH]
        ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
        : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign iter = funct_q[2] ? div_next : mul_next;

    assign prod = neg_q ? -iter : iter;
    assign quo  = neg_q ? -iter[WIDTH-1:0] : iter[WIDTH-1:0];
    assign rem  = rneg_q ? -iter[2*WIDTH-1:WIDTH]
                         : iter[2*WIDTH-1:WIDTH];

    always_comb begin
        final_res = rem;
        unique case (funct_q)
            3'b000:                 final_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct_d  = funct_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;
        BusyE    = 1'b0;
        unique case (state_q)
            IDLE: begin
                BusyE = StartE & ~FlushE;
                if (StartE && !FlushE) begin
                    funct_d = FunctE;
                    b_d     = b_mag;
                    acc_d   = {{WIDTH{1'b0}}, a_mag};
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                BusyE = ~FlushE;
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    acc_d = iter;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        result_d = final_res;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct_q  <= funct_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign DoneE   = done_q;
    assign ResultE = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the
// RV32M rules plus randomized ops against an arithmetic model.
module tb_muldiv_unit;
    logic        clk;
    logic        rst_n;
    logic        StartE;
    logic [2:0]  FunctE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = 32'h0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .StartE  (StartE),
        .FunctE  (FunctE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .FlushE  (FlushE),
        .BusyE   (BusyE),
        .DoneE   (DoneE),
        .ResultE (ResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M semantics with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge
    // following DONE (an IDLE cycle, ready for a back-to-back op).
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] exp;
        exp = model(f, a, b);
        StartE = 1'b1;
        FunctE = f;
        SrcAE  = a;
        SrcBE  = b;
        #1;
        check({tag, " busy_accept"}, 32'(BusyE), 32'd1);
        @(posedge clk);
        #1;
        StartE = 1'b0;
        SrcAE  = $urandom;
        SrcBE  = $urandom;
        n = 1;
        while (!DoneE && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(latency(f, a, b)));
        check({tag, " busy_done"}, 32'(BusyE), 32'd0);
        check({tag, " result"}, ResultE, exp);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 32'(DoneE), 32'd0);
        check({tag, " hold"}, ResultE, exp);
        last_res = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        logic [2:0] rf;
        logic [31:0] ra, rb;
        rst_n  = 1'b0;
        StartE = 1'b0;
        FunctE = 3'd0;
        SrcAE  = 32'h0;
        SrcBE  = 32'h0;
        FlushE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(BusyE), 32'd0);
        check("rst done", 32'(DoneE), 32'd0);
        check("rst result", ResultE, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mul value", last_res, 32'hFFFF_FFEB);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 3'd5, 32'd100, 32'd7);
        run_op("remu", 3'd7, 32'd100, 32'd7);
        run_op("divu0", 3'd5, 32'd5, 32'd0);
        run_op("remu0", 3'd7, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush at CALC iteration 10
        StartE = 1'b1;
        FunctE = 3'd0;
        SrcAE  = 32'd1234;
        SrcBE  = 32'd5678;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush busy_before", 32'(BusyE), 32'd1);
        FlushE = 1'b1;
        #1;
        check("flush busy_drop", 32'(BusyE), 32'd0);
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (DoneE) dones++;
            @(posedge clk);
            #1;
        end
        check("flush no_done", 32'(dones), 32'd0);
        check("flush result_kept", ResultE, last_res);
        check("flush idle_busy", 32'(BusyE), 32'd0);
        run_op("divu_after_flush", 3'd5, 32'd9, 32'd3);

        // Reset in the middle of CALC
        StartE = 1'b1;
        FunctE = 3'd5;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd3;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(BusyE), 32'd0);
        check("midrst done", 32'(DoneE), 32'd0);
        check("midrst result", ResultE, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4);

        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
